// File: rtl/spi_ram_cmd_mem_pkg.sv
// Shared definitions for the SPI RAM command memory: default geometry and
// the 2-bit command encoding carried in the top bits of each SPI word.
package spi_ram_cmd_mem_pkg;

  localparam int MEM_WIDTH_DEF = 8;
  localparam int MEM_DEPTH_DEF = 256;
  localparam int ADDR_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } ram_cmd_e;

endpackage

// File: rtl/spi_ram_cmd_mem_if.sv
// Word-level handshake between the SPI slave (master side) and the RAM
// command memory (slave side).
interface spi_ram_cmd_mem_if #(
  parameter int MEM_WIDTH = spi_ram_cmd_mem_pkg::MEM_WIDTH_DEF
);
  logic [MEM_WIDTH+1:0] din;
  logic                 rx_valid;
  logic [MEM_WIDTH-1:0] dout;
  logic                 tx_valid;
  logic                 cmd_err;

  modport master (output din, output rx_valid,
                  input  dout, input tx_valid, input cmd_err);
  modport slave  (input  din, input  rx_valid,
                  output dout, output tx_valid, output cmd_err);
endinterface

// File: rtl/spi_ram_array.sv
// Storage for the SPI RAM: one synchronous write port and one synchronous
// read port with enable. The read register holds until the next enabled
// read; only that register is reset, the array contents survive reset.
module spi_ram_array #(
  parameter int MEM_WIDTH = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [MEM_WIDTH-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [MEM_WIDTH-1:0] rdata
);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic [MEM_WIDTH-1:0] rdata_q, rdata_d;

  // Write port; no reset so contents are retained across rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read data selection: capture the addressed word only when enabled.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Registered read output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_cmd_mem.sv
// SPI RAM command memory: decodes {cmd, payload} words from the SPI slave,
// holds write/read address registers with their valid flags, drives the
// storage array and returns read data with a one-cycle tx_valid pulse.
// Optional feature macro: SPI_RAM_ADDR_AUTO_INC_EN (post-increment of the
// write/read address after each successful data command, wrapping at
// MEM_DEPTH).
module spi_ram_cmd_mem
  import spi_ram_cmd_mem_pkg::*;
#(
  parameter int MEM_WIDTH = MEM_WIDTH_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_ram_cmd_mem_if.slave  bus
);

  localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE+1)'(MEM_DEPTH);

  ram_cmd_e             cmd;
  logic [MEM_WIDTH-1:0] payload;

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_addr_vld_q, wr_addr_vld_d;
  logic                 rd_addr_vld_q, rd_addr_vld_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 rd_oor_q, rd_oor_d;

  logic                 mem_we;
  logic                 mem_re;
  logic [MEM_WIDTH-1:0] mem_rdata;

  assign cmd     = ram_cmd_e'(bus.din[MEM_WIDTH+1:MEM_WIDTH]);
  assign payload = bus.din[MEM_WIDTH-1:0];

  function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

`ifdef SPI_RAM_ADDR_AUTO_INC_EN
  // Anything at or beyond the last word wraps to 0, covering both the
  // normal MEM_DEPTH-1 wrap and stray out-of-range addresses.
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    if ({1'b0, a} >= DEPTH_W - 1'b1) return '0;
    return a + 1'b1;
  endfunction
`endif

  // Command decode: address/flag updates, memory strobes and response pulses.
  always_comb begin
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_vld_d = wr_addr_vld_q;
    rd_addr_vld_d = rd_addr_vld_q;
    tx_valid_d    = 1'b0;
    cmd_err_d     = 1'b0;
    rd_oor_d      = rd_oor_q;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    if (bus.rx_valid) begin
      unique case (cmd)
        WR_ADDR: begin
          wr_addr_d     = payload[ADDR_SIZE-1:0];
          wr_addr_vld_d = 1'b1;
        end
        WR_DATA: begin
          if (wr_addr_vld_q) begin
            mem_we = in_range(wr_addr_q);
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
            wr_addr_d = next_addr(wr_addr_q);
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        RD_ADDR: begin
          rd_addr_d     = payload[ADDR_SIZE-1:0];
          rd_addr_vld_d = 1'b1;
        end
        RD_DATA: begin
          if (rd_addr_vld_q) begin
            tx_valid_d = 1'b1;
            mem_re     = in_range(rd_addr_q);
            // Out-of-range reads leave the array register alone and mask
            // dout to zero until the next read.
            rd_oor_d   = !in_range(rd_addr_q);
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
            rd_addr_d  = next_addr(rd_addr_q);
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Decode state and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wr_addr_vld_q <= 1'b0;
      rd_addr_vld_q <= 1'b0;
      tx_valid_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
      rd_oor_q      <= 1'b0;
    end else begin
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_vld_q <= wr_addr_vld_d;
      rd_addr_vld_q <= rd_addr_vld_d;
      tx_valid_q    <= tx_valid_d;
      cmd_err_q     <= cmd_err_d;
      rd_oor_q      <= rd_oor_d;
    end
  end

  spi_ram_array #(
    .MEM_WIDTH (MEM_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (wr_addr_q),
    .wdata (payload),
    .re    (mem_re),
    .raddr (rd_addr_q),
    .rdata (mem_rdata)
  );

  assign bus.dout     = rd_oor_q ? '0 : mem_rdata;
  assign bus.tx_valid = tx_valid_q;
  assign bus.cmd_err  = cmd_err_q;

endmodule
